// File: rtl/uart_tx_pkg.sv
// Shared encodings and parameter legality helpers for the UART transmitter.
package uart_tx_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Serial line levels
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  localparam int unsigned DATA_WIDTH_MIN = 5;
  localparam int unsigned DATA_WIDTH_MAX = 9;

  function automatic bit data_width_ok(input int unsigned w);
    return (w >= DATA_WIDTH_MIN) && (w <= DATA_WIDTH_MAX);
  endfunction

  function automatic bit stop_bits_ok(input int unsigned s);
    return (s == 1) || (s == 2);
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register, data-bit counter and parity XOR for one frame.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_enter,
  input  logic                  i_shift,
  output logic                  o_bit,
  output logic                  o_done,
  output logic                  o_xor
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_xor;

  // Capture payload on load; shift out LSB-first, counter restarts on DATA entry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_xor   <= 1'b0;
    end else if (i_load) begin
      r_shreg <= i_data;
      r_xor   <= ^i_data;
    end else if (i_enter || i_shift) begin
      r_shreg <= r_shreg >> 1;
      r_cnt   <= i_enter ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_bit  = r_shreg[0];
  assign o_done = (r_cnt == CNT_W'(DATA_WIDTH - 1));
  assign o_xor  = r_xor;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frame FSM with fully registered line and handshake outputs.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  data_ready,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_done
);

  if (!data_width_ok(DATA_WIDTH)) begin : g_bad_width
    $error("uart_tx_ctrl: DATA_WIDTH must be in 5..9");
  end
  if (!stop_bits_ok(STOP_BITS)) begin : g_bad_stop
    $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
  end

  localparam logic [0:0] STOP_LAST = 1'(STOP_BITS - 1);

  logic [2:0] r_state;
  logic [0:0] r_stop_cnt;
  logic       r_par_en;
  logic       r_par_typ;
  logic       r_tx;
  logic       r_busy;
  logic       r_ready;
  logic       r_done;

  logic [2:0] w_state_n;
  logic [0:0] w_stop_n;
  logic       w_tx_n;
  logic       w_accept;
  logic       w_load;
  logic       w_enter;
  logic       w_shift;
  logic       w_last_stop_n;
  logic       w_bit;
  logic       w_done;
  logic       w_xor;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_load  (w_load),
    .i_data  (P_DATA),
    .i_enter (w_enter),
    .i_shift (w_shift),
    .o_bit   (w_bit),
    .o_done  (w_done),
    .o_xor   (w_xor)
  );

  // Next state and next line level; outputs are registered from the next state,
  // so the line always shows the bit belonging to the state being occupied.
  always_comb begin
    w_accept  = data_valid & r_ready;
    w_state_n = r_state;
    w_stop_n  = r_stop_cnt;
    w_tx_n    = LINE_IDLE;
    w_load    = 1'b0;
    w_enter   = 1'b0;
    w_shift   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_n = ST_START;
          w_load    = 1'b1;
          w_tx_n    = LINE_START;
        end
      end
      ST_START: begin
        w_state_n = ST_DATA;
        w_enter   = 1'b1;
        w_tx_n    = w_bit;
      end
      ST_DATA: begin
        if (!w_done) begin
          w_shift = 1'b1;
          w_tx_n  = w_bit;
        end else if (r_par_en) begin
          w_state_n = ST_PARITY;
          w_tx_n    = w_xor ^ r_par_typ;
        end else begin
          w_state_n = ST_STOP;
          w_stop_n  = '0;
          w_tx_n    = LINE_STOP;
        end
      end
      ST_PARITY: begin
        w_state_n = ST_STOP;
        w_stop_n  = '0;
        w_tx_n    = LINE_STOP;
      end
      ST_STOP: begin
        if (r_stop_cnt == STOP_LAST) begin
          if (w_accept) begin
            w_state_n = ST_START;
            w_load    = 1'b1;
            w_tx_n    = LINE_START;
          end else begin
            w_state_n = ST_IDLE;
          end
        end else begin
          w_stop_n = r_stop_cnt + 1'b1;
          w_tx_n   = LINE_STOP;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
    w_last_stop_n = (w_state_n == ST_STOP) && (w_stop_n == STOP_LAST);
  end

  // State, captured frame options and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_stop_cnt <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_tx       <= LINE_IDLE;
      r_busy     <= 1'b0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_stop_cnt <= w_stop_n;
      r_tx       <= w_tx_n;
      r_busy     <= (w_state_n != ST_IDLE);
      r_ready    <= (w_state_n == ST_IDLE) || w_last_stop_n;
      r_done     <= w_last_stop_n;
      if (w_load) begin
        r_par_en  <= par_en;
        r_par_typ <= par_typ;
      end
    end
  end

  assign data_ready = r_ready;
  assign TX_OUT     = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule
